// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-period helper.
// Used by uart_receive and uart_transmit so both ends agree on bit timing.
package uart_pkg;

    // Receiver FSM states. PARITY is only visited in the 8E1 build.
    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5
    } rx_state_t;

    // Clock cycles per bit; integer division matches uart_transmit exactly.
    function automatic int baud_period(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_receive_sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs (uart rx, buttons,
// SPI cipo). RESET_VAL sets both flops during reset so the synchronised
// output starts at the line's idle level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Two-stage capture of the async pin; first stage may go metastable.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            meta     <= RESET_VAL;
            sync_out <= RESET_VAL;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_receive.sv
// uart_receive: UART receiver, 8N1 LSB first, for the FTDI2232 host link.
// The raw line is synchronised, each bit is majority-voted from three samples
// around its centre, and a good frame produces a one-cycle valid pulse.
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames, which adds an
// even-parity bit after data bit 7 and the parity_error_out port.
module uart_receive
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 460800
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_wire_in,
    output logic [7:0] data_byte_out,
    output logic       valid_out,
    output logic       framing_error_out,
`ifdef UART_RX_PARITY_EN
    output logic       parity_error_out,
`endif
    output logic       busy_out
);

    localparam int BAUD_PERIOD = baud_period(CLK_FREQ, BAUD_RATE);
    localparam int HALF        = BAUD_PERIOD / 2;
    localparam int CNT_W       = $clog2(BAUD_PERIOD);

    localparam logic [CNT_W-1:0] SAMPLE_A = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SAMPLE_B = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] SAMPLE_C = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_PERIOD - 1);

    // 2-of-3 vote; a single corrupted sample cannot flip the bit.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             rx_sync;
    logic [CNT_W-1:0] bit_cnt;
    logic             samp_a;
    logic             samp_b;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             bit_val;
    logic             at_decide;
    logic             at_end;
    logic             cnt_clr;
    logic             shift_en;
    logic             idx_inc;
    logic             emit_byte;
    logic             emit_fe;
`ifdef UART_RX_PARITY_EN
    logic             par_bad;
    logic             par_latch;
    logic             emit_pe;
`endif

    // The only consumer of the raw pin: resync into the clk_in domain.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .async_in (rx_wire_in),
        .sync_out (rx_sync)
    );

    assign bit_val   = majority3(samp_a, samp_b, rx_sync);
    assign at_decide = (bit_cnt == SAMPLE_C);
    assign at_end    = (bit_cnt == CNT_LAST);
    assign busy_out  = (state != IDLE);

    // FSM state register; reset parks in WAIT_IDLE until the line is high.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle strobes for the timer, shifter and outputs.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        idx_inc   = 1'b0;
        emit_byte = 1'b0;
        emit_fe   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_latch = 1'b0;
        emit_pe   = 1'b0;
`endif
        case (state)
            WAIT_IDLE: begin
                if (rx_sync) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (!rx_sync) begin
                    state_nxt = START;
                    cnt_clr   = 1'b1;
                end
            end
            START: begin
                if (at_decide && bit_val) begin
                    // Low pulse too short to be a start bit.
                    state_nxt = IDLE;
                end else if (at_end) begin
                    state_nxt = DATA;
                    cnt_clr   = 1'b1;
                end
            end
            DATA: begin
                if (at_decide) begin
                    shift_en = 1'b1;
                end
                if (at_end) begin
                    cnt_clr = 1'b1;
                    idx_inc = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_decide) begin
                    par_latch = 1'b1;
                end
                if (at_end) begin
                    state_nxt = STOP;
                    cnt_clr   = 1'b1;
                end
            end
`endif
            STOP: begin
                // Leave at the decision point so a new start edge can be
                // caught during the second half of the stop bit.
                if (at_decide) begin
                    if (bit_val) begin
                        state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad) begin
                            emit_pe = 1'b1;
                        end else begin
                            emit_byte = 1'b1;
                        end
`else
                        emit_byte = 1'b1;
`endif
                    end else begin
                        state_nxt = WAIT_IDLE;
                        emit_fe   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = WAIT_IDLE;
            end
        endcase
    end

    // Data-bit index; restarts from zero each time the receiver is idle.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bit_idx <= 3'd0;
        end else if (state == IDLE) begin
            bit_idx <= 3'd0;
        end else if (idx_inc) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // Bit timer plus the two early samples feeding the majority vote.
    always_ff @(posedge clk_in) begin
        if (cnt_clr) begin
            bit_cnt <= '0;
        end else if (!at_end) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
        if (bit_cnt == SAMPLE_A) begin
            samp_a <= rx_sync;
        end
        if (bit_cnt == SAMPLE_B) begin
            samp_b <= rx_sync;
        end
    end

    // LSB-first shift register: each voted bit enters at the top.
    always_ff @(posedge clk_in) begin
        if (shift_en) begin
            shift <= {bit_val, shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: a mismatch between the received bit and XOR of the data.
    always_ff @(posedge clk_in) begin
        if (par_latch) begin
            par_bad <= bit_val ^ (^shift);
        end
    end
`endif

    // Registered outputs: byte is only loaded by a fully checked frame.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            data_byte_out     <= 8'h00;
            valid_out         <= 1'b0;
            framing_error_out <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_out  <= 1'b0;
`endif
        end else begin
            valid_out         <= emit_byte;
            framing_error_out <= emit_fe;
`ifdef UART_RX_PARITY_EN
            parity_error_out  <= emit_pe;
`endif
            if (emit_byte) begin
                data_byte_out <= shift;
            end
        end
    end

endmodule
